// File: rtl/mem_bus_pkg.sv
`default_nettype none
//============================================================================
// Module : mem_bus_pkg
// Brief  : Shared FSM state type and default address map for mem_bus_controller
// Rev    : 1.0 - initial release
//============================================================================
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  localparam int c_DEFAULT_TIMEOUT = 16;

  // Slave 3 in the upper word down to slave 0 in the lower word.
  localparam logic [127:0] c_DEFAULT_BASE = {32'h1001_0110, 32'h1001_0100,
                                             32'h0040_0000, 32'h1001_0000};
  localparam logic [127:0] c_DEFAULT_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                             32'hFFFF_F000, 32'hFFFF_FF00};

endpackage
`default_nettype wire

// File: rtl/mem_bus_if.sv
`default_nettype none
//============================================================================
// Module : mem_bus_if
// Brief  : Control-unit request bus plus slave-side select/strobe/data bus
// Rev    : 1.0 - initial release
//============================================================================
interface mem_bus_if #(
  parameter int ADDR_LENGTH = 32,
  parameter int DATA_LENGTH = 32,
  parameter int NUM_SLAVES  = 4
);
  logic                              MemRead;
  logic                              MemWrite;
  logic [ADDR_LENGTH-1:0]            AddrIn;
  logic [DATA_LENGTH-1:0]            DataIn;
  logic [DATA_LENGTH-1:0]            DataOut;
  logic                              Ready;
  logic                              Error;
  logic [ADDR_LENGTH-1:0]            AddrOut;
  logic [DATA_LENGTH-1:0]            WrData;
  logic [NUM_SLAVES-1:0]             Select;
  logic                              Write;
  logic                              Read;
  logic [NUM_SLAVES*DATA_LENGTH-1:0] SlaveData;
  logic [NUM_SLAVES-1:0]             SlaveReady;

  // Controller view.
  modport master (
    input  MemRead, MemWrite, AddrIn, DataIn, SlaveData, SlaveReady,
    output DataOut, Ready, Error, AddrOut, WrData, Select, Write, Read
  );

  // Environment view: control unit and slave devices.
  modport slave (
    output MemRead, MemWrite, AddrIn, DataIn, SlaveData, SlaveReady,
    input  DataOut, Ready, Error, AddrOut, WrData, Select, Write, Read
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_addr_decode.sv
`default_nettype none
//============================================================================
// Module : mem_bus_addr_decode
// Brief  : Combinational base/mask address match, lowest slave index wins
// Rev    : 1.0 - initial release
//============================================================================
module mem_bus_addr_decode #(
  parameter int ADDR_LENGTH = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int IDX_W       = 2,
  parameter logic [NUM_SLAVES*ADDR_LENGTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_LENGTH-1:0] SLAVE_MASK = '0
) (
  input  wire logic [ADDR_LENGTH-1:0] i_addr,
  output logic                        o_hit,
  output logic [IDX_W-1:0]            o_idx
);

  // Scan downward so a lower-index match overwrites a higher one.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & SLAVE_MASK[i*ADDR_LENGTH +: ADDR_LENGTH]) ==
          SLAVE_BASE[i*ADDR_LENGTH +: ADDR_LENGTH]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_controller.sv
`default_nettype none
//============================================================================
// Module : mem_bus_controller
// Brief  : Memory-mapped bus controller with wait states and bus-error timeout
// Rev    : 1.0 - initial release
//============================================================================
module mem_bus_controller
  import mem_bus_pkg::*;
#(
  parameter int ADDR_LENGTH    = 32,
  parameter int DATA_LENGTH    = 32,
  parameter int NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*ADDR_LENGTH-1:0] SLAVE_BASE =
    (NUM_SLAVES*ADDR_LENGTH)'(c_DEFAULT_BASE),
  parameter logic [NUM_SLAVES*ADDR_LENGTH-1:0] SLAVE_MASK =
    (NUM_SLAVES*ADDR_LENGTH)'(c_DEFAULT_MASK),
  parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT
) (
  input wire logic  clk,
  input wire logic  rst,
  mem_bus_if.master bus
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]      c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_SLAVES-1:0] c_ONE      = NUM_SLAVES'(1);

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_W-1:0]       r_count;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_is_read;
  logic [DATA_LENGTH-1:0] r_data_out;
  logic                   r_ready;
  logic                   r_error;
  logic [ADDR_LENGTH-1:0] r_addr_out;
  logic [DATA_LENGTH-1:0] r_wr_data;
  logic [NUM_SLAVES-1:0]  r_select;
  logic                   r_read;
  logic                   r_write;

  logic                   w_dec_hit;
  logic [IDX_W-1:0]       w_dec_idx;
  logic [IDX_W-1:0]       w_sel_idx;
  logic                   w_cur_read;
  logic                   w_slave_ready;
  logic [DATA_LENGTH-1:0] w_slave_data;

  mem_bus_addr_decode #(
    .ADDR_LENGTH (ADDR_LENGTH),
    .NUM_SLAVES  (NUM_SLAVES),
    .IDX_W       (IDX_W),
    .SLAVE_BASE  (SLAVE_BASE),
    .SLAVE_MASK  (SLAVE_MASK)
  ) u_decode (
    .i_addr (bus.AddrIn),
    .o_hit  (w_dec_hit),
    .o_idx  (w_dec_idx)
  );

  assign w_slave_ready = bus.SlaveReady[r_idx];
  assign w_slave_data  = bus.SlaveData[r_idx*DATA_LENGTH +: DATA_LENGTH];

  // On the accept edge the latched slot is not yet loaded, so use the decoder.
  assign w_sel_idx  = (r_state == ST_IDLE) ? w_dec_idx    : r_idx;
  assign w_cur_read = (r_state == ST_IDLE) ? bus.MemRead  : r_is_read;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          w_next = ((bus.MemRead ^ bus.MemWrite) && w_dec_hit) ? ST_ACCESS : ST_ERROR;
        end
      end
      ST_ACCESS: begin
        if (!bus.MemRead && !bus.MemWrite) begin
          w_next = ST_IDLE;
        end else if (w_slave_ready) begin
          w_next = ST_DONE;
        end else if (r_count == c_CNT_LAST) begin
          w_next = ST_ERROR;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // All bus-facing outputs are decoded from the next state and registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_idx      <= '0;
      r_is_read  <= 1'b0;
      r_data_out <= '0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
      r_addr_out <= '0;
      r_wr_data  <= '0;
      r_select   <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_DONE) || (w_next == ST_ERROR);
      r_error <= (w_next == ST_ERROR);

      if (r_state == ST_IDLE && w_next == ST_ACCESS) begin
        r_addr_out <= bus.AddrIn;
        r_wr_data  <= bus.DataIn;
        r_is_read  <= bus.MemRead;
        r_idx      <= w_dec_idx;
        r_count    <= '0;
      end else if (r_state == ST_ACCESS && r_count != c_CNT_LAST) begin
        r_count <= r_count + 1'b1;
      end

      if (w_next == ST_ERROR) begin
        r_data_out <= '0;
      end else if (r_state == ST_ACCESS && w_next == ST_DONE && r_is_read) begin
        r_data_out <= w_slave_data;
      end

      if (w_next == ST_ACCESS) begin
        r_select <= c_ONE << w_sel_idx;
        r_read   <= w_cur_read;
        r_write  <= ~w_cur_read;
      end else begin
        r_select <= '0;
        r_read   <= 1'b0;
        r_write  <= 1'b0;
      end
    end
  end

  assign bus.DataOut = r_data_out;
  assign bus.Ready   = r_ready;
  assign bus.Error   = r_error;
  assign bus.AddrOut = r_addr_out;
  assign bus.WrData  = r_wr_data;
  assign bus.Select  = r_select;
  assign bus.Read    = r_read;
  assign bus.Write   = r_write;

endmodule
`default_nettype wire

// File: doc/mem_bus_controller.md
MEM_BUS_CONTROLLER -- requirements
Module: mem_bus_controller

Interface
REQ-001 SHALL have parameter ADDR_LENGTH, default 32, address width.
REQ-002 SHALL have parameter DATA_LENGTH, default 32, data width.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, range 1..16, number of mapped devices.
REQ-004 SHALL have parameter SLAVE_BASE, default {0x1001_0110, 0x1001_0100, 0x0040_0000, 0x1001_0000} (slave 3..0), flattened NUM_SLAVES*ADDR_LENGTH base addresses.
REQ-005 SHALL have parameter SLAVE_MASK, default {0xFFFF_FFF0, 0xFFFF_FFF0, 0xFFFF_F000, 0xFFFF_FF00} (slave 3..0), flattened match masks.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 16, wait-state limit before bus error.
REQ-007 SHALL have ports: clk  in  1  single system clock, rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 MemRead  in  1  read request from control unit, held until Ready.
REQ-010 MemWrite  in  1  write request from control unit, held until Ready.
REQ-011 AddrIn  in  ADDR_LENGTH  request address.
REQ-012 DataIn  in  DATA_LENGTH  write data.
REQ-013 DataOut  out  DATA_LENGTH  registered read data.
REQ-014 Ready  out  1  one-cycle completion pulse.
REQ-015 Error  out  1  one-cycle bus-error pulse, coincident with Ready.
REQ-016 AddrOut  out  ADDR_LENGTH  registered address to slaves.
REQ-017 WrData  out  DATA_LENGTH  registered write data to slaves.
REQ-018 Select  out  NUM_SLAVES  one-hot chip select.
REQ-019 Write, Read  out  1 each  strobes, valid only with a Select bit.
REQ-020 SlaveData  in  NUM_SLAVES*DATA_LENGTH  flattened slave read data.
REQ-021 SlaveReady  in  NUM_SLAVES  per-slave access-complete flag.

Function
REQ-022 SHALL implement FSM states IDLE, ACCESS, DONE, ERROR.
REQ-023 IDLE: MemRead xor MemWrite with address match -> latch AddrIn/DataIn/direction/slave index, go ACCESS.
REQ-024 IDLE: match = ((AddrIn & SLAVE_MASK[i]) == SLAVE_BASE[i]); multiple matches -> lowest index wins.
REQ-025 IDLE: no match, or MemRead and MemWrite both high -> ERROR.
REQ-026 ACCESS: Select[idx] and Read/Write high; wait counter increments each cycle from 0.
REQ-027 ACCESS: SlaveReady[idx] high -> capture SlaveData[idx] into DataOut (reads only; writes leave DataOut unchanged), go DONE; minimum latency request-to-Ready = 2 cycles.
REQ-028 ACCESS: counter == TIMEOUT_CYCLES-1 without SlaveReady -> deassert Select, go ERROR; SlaveReady in that same cycle wins over timeout.
REQ-029 ACCESS: both MemRead and MemWrite low (request withdrawn) -> deassert Select, IDLE, no Ready.
REQ-030 DONE: Ready=1 for one cycle, Select=0, go IDLE; new request accepted from next IDLE cycle only.
REQ-031 ERROR: Ready=1, Error=1 for one cycle, DataOut=0, go IDLE.
REQ-032 Select, Read, Write SHALL be registered outputs, glitch-free, at most one Select bit high.
REQ-033 Counter width SHALL be clog2(TIMEOUT_CYCLES)+1; no wrap before timeout.

Reset
REQ-034 rst high SHALL asynchronously force IDLE, counter 0, DataOut 0, AddrOut 0, WrData 0, Select 0, Read 0, Write 0, Ready 0, Error 0.
REQ-035 rst mid-ACCESS SHALL abort the transfer with no Ready; first request after release is treated as new.

Structure
REQ-036 Package mem_bus_pkg SHALL hold FSM state type, default base/mask constants, and default TIMEOUT_CYCLES.
REQ-037 Sub-module mem_bus_addr_decode SHALL hold the combinational priority match (address in, hit flag and index out).

Verification
REQ-038 Read 0x1001_0004, slave 0 SlaveReady immediately, SlaveData=0x1234_5678 -> Ready at cycle 2, DataOut=0x1234_5678, Error=0.
REQ-039 Write 0x1001_0100 data 0xA5, slave 2 ready after 3 wait cycles -> Select=0100, Write=1 for 4 cycles, WrData=0xA5, Ready once.
REQ-040 Read 0x2000_0000 (unmapped) -> ERROR, Ready=Error=1 next cycle, DataOut=0, no Select.
REQ-041 Read 0x0040_0000, slave 1 never ready -> Select high for exactly 16 cycles, then Ready=Error=1.
REQ-042 MemRead and MemWrite both high -> Error; rst asserted mid-ACCESS -> all outputs 0 asynchronously, no Ready.
